// File: rtl/simple_pkg.sv
// ----------------------------------------------------------------------------
// simple_pkg
// Shared constants and types for the simple_circuit benchmark block.
//   STATE_W / IN_W : widths of the feedback state and the input vector
//   STATE_RST      : value the state register takes on reset
//   OUT_RST        : value both registered outputs take on reset
//   state_t        : type of the 3-bit feedback state register
//   maj3 / par3    : 3-input majority and parity helpers used by the cloud
// ----------------------------------------------------------------------------
package simple_pkg;

    localparam int STATE_W = 3;
    localparam int IN_W    = 3;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [IN_W-1:0]    in_vec_t;

    localparam state_t STATE_RST = 3'b000;
    localparam logic   OUT_RST   = 1'b0;

    // True when at least two of the three bits are set.
    function automatic logic maj3(input in_vec_t v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

    // Odd parity of the three bits.
    function automatic logic par3(input in_vec_t v);
        return v[0] ^ v[1] ^ v[2];
    endfunction

endpackage : simple_pkg

// File: rtl/simple_circuit_logic.sv
// ----------------------------------------------------------------------------
// simple_logic
// Purely combinational cloud of simple_circuit.
// Ports:
//   in_q    in  [2:0] input vector ({in2,in1,in0}, registered or direct)
//   s       in  [2:0] current feedback state
//   maj     out       majority of in_q
//   o1_next out       parity of in_q XOR s[2]
//   s_next  out [2:0] next state: shift left, feed s[2]^in_q[0]^in_q[1] into LSB
// ----------------------------------------------------------------------------
module simple_logic
    import simple_pkg::*;
(
    input  logic [IN_W-1:0] in_q,
    input  state_t          s,
    output logic            maj,
    output logic            o1_next,
    output state_t          s_next
);

    logic par;
    logic fb_bit;

    always_comb begin
        maj     = maj3(in_q);
        par     = par3(in_q);
        // out1 looks at the state MSB before this edge's state update.
        o1_next = par ^ s[STATE_W-1];
        // Feedback deliberately excludes in_q[2]; only bits 0 and 1 steer the state.
        fb_bit  = s[STATE_W-1] ^ in_q[0] ^ in_q[1];
        s_next  = {s[STATE_W-2:0], fb_bit};
    end

endmodule : simple_logic

// File: rtl/simple_circuit.sv
// ----------------------------------------------------------------------------
// simple_circuit
// Small synchronous benchmark: optional input register, a combinational
// majority/parity cloud (simple_logic), a 3-bit feedback state and two
// registered outputs.
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   synchronous active-low reset; clears in_q, s, out0, out1
//   in0..2 in   data input bits
//   out0   out  registered majority of the inputs
//   out1   out  registered parity of the inputs XOR state MSB
// Configuration macro:
//   SIMPLE_IN_REG_EN  defined   -> inputs pass through in_q flops (2-edge latency)
//                     undefined -> cloud reads the ports directly (1-edge latency)
// ----------------------------------------------------------------------------
module simple_circuit
    import simple_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic out0,
    output logic out1
);

    logic [IN_W-1:0] in_vec;
    logic [IN_W-1:0] cloud_in;

    state_t s_q;
    state_t s_d;
    logic   out0_q;
    logic   out0_d;
    logic   out1_q;
    logic   out1_d;

    assign in_vec = {in2, in1, in0};

`ifdef SIMPLE_IN_REG_EN
    logic [IN_W-1:0] in_q_q;
    logic [IN_W-1:0] in_q_d;

    always_comb begin
        in_q_d = in_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q_q <= '0;
        end else begin
            in_q_q <= in_q_d;
        end
    end

    assign cloud_in = in_q_q;
`else
    // Input stage removed: the cloud sees the pins in the same cycle.
    assign cloud_in = in_vec;
`endif

    simple_logic u_logic (
        .in_q    (cloud_in),
        .s       (s_q),
        .maj     (out0_d),
        .o1_next (out1_d),
        .s_next  (s_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= STATE_RST;
            out0_q <= OUT_RST;
            out1_q <= OUT_RST;
        end else begin
            s_q    <= s_d;
            out0_q <= out0_d;
            out1_q <= out1_d;
        end
    end

    // Outputs come straight from flops so they cannot glitch.
    assign out0 = out0_q;
    assign out1 = out1_q;

endmodule : simple_circuit

// File: tb/tb_simple_circuit.sv
// ----------------------------------------------------------------------------
// tb_simple_circuit
// Self-checking bench for simple_circuit. Works with SIMPLE_IN_REG_EN either
// defined or undefined; the reference model follows the selected latency.
// ----------------------------------------------------------------------------
module tb_simple_circuit;

    logic clk;
    logic rst_n;
    logic in0;
    logic in1;
    logic in2;
    logic out0;
    logic out1;

`ifdef SIMPLE_IN_REG_EN
    localparam bit IN_REG = 1'b1;
`else
    localparam bit IN_REG = 1'b0;
`endif

    simple_circuit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (in0),
        .in1   (in1),
        .in2   (in2),
        .out0  (out0),
        .out1  (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table for the cloud: one record per input value.
    typedef struct {
        logic [2:0] in_v;
        logic       exp_maj;
        logic       exp_par;
    } vec_t;

    vec_t tbl [8];

    int n_vec  = 0;
    int n_miss = 0;

    logic [1:0] sb_q [$];   // {out0, out1} expected after each edge
    logic [2:0] m_inq;
    logic [2:0] m_s;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs after the coming edge, pushed when driven.
    task automatic model_push(input logic r, input logic [2:0] x);
        logic [2:0] eff;
        logic       e0;
        logic       e1;
        if (!r) begin
            e0    = 1'b0;
            e1    = 1'b0;
            m_inq = 3'b000;
            m_s   = 3'b000;
        end else begin
            eff = IN_REG ? m_inq : x;
            e0  = tbl[eff].exp_maj;
            e1  = tbl[eff].exp_par ^ m_s[2];
            m_s = {m_s[1:0], m_s[2] ^ eff[0] ^ eff[1]};
            if (IN_REG) m_inq = x;
        end
        sb_q.push_back({e0, e1});
    endtask

    task automatic step(input string name, input logic r, input logic [2:0] x);
        logic [1:0] exp;
        @(negedge clk);
        rst_n = r;
        {in2, in1, in0} = x;
        model_push(r, x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: scoreboard empty, got %b%b expected an entry", name, out0, out1);
        end else begin
            exp = sb_q.pop_front();
            check_bit({name, ".out0"}, out0, exp[1]);
            check_bit({name, ".out1"}, out1, exp[0]);
            $display("%s rst_n=%b in=%b out0=%b out1=%b exp=%b%b", name, r, x, out0, out1, exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [2:0] rx;
        logic       rr;
        logic       seq_exp [12];

        tbl[0] = '{3'b000, 1'b0, 1'b0};
        tbl[1] = '{3'b001, 1'b0, 1'b1};
        tbl[2] = '{3'b010, 1'b0, 1'b1};
        tbl[3] = '{3'b011, 1'b1, 1'b0};
        tbl[4] = '{3'b100, 1'b0, 1'b1};
        tbl[5] = '{3'b101, 1'b1, 1'b0};
        tbl[6] = '{3'b110, 1'b1, 1'b0};
        tbl[7] = '{3'b111, 1'b1, 1'b1};

        m_inq = 3'b000;
        m_s   = 3'b000;
        rst_n = 1'b0;
        {in2, in1, in0} = 3'b111;

        // Reset must clear the outputs whatever the inputs are.
        step("reset", 1'b0, 3'b111);
        step("reset", 1'b0, 3'b101);

        // Hold each input pattern after a fresh reset.
        for (int i = 0; i < 8; i++) begin
            step("tbl_rst", 1'b0, tbl[i].in_v);
            for (int c = 0; c < 14; c++) begin
                step($sformatf("tbl_in%b", tbl[i].in_v), 1'b1, tbl[i].in_v);
            end
        end

        // Hand sequence: in=001 after reset, out1 checked against fixed constants.
        // State walks 000,001,011,111,110,100 so parity 1 ^ s[2] gives 1,1,1,0,0,0.
        seq_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        step("seq_rst", 1'b0, 3'b001);
        if (IN_REG) begin
            // First edge after release only loads in_q; cloud still sees 000.
            step("seq_fill", 1'b1, 3'b001);
            check_bit("seq_fill.out1", out1, 1'b0);
        end
        for (int c = 0; c < 12; c++) begin
            step("seq001", 1'b1, 3'b001);
            check_bit($sformatf("seq001[%0d].out1", c), out1, seq_exp[c]);
            check_bit($sformatf("seq001[%0d].out0", c), out0, 1'b0);
        end

        // Mid-operation reset pulse, then the sequence restarts from scratch.
        for (int c = 0; c < 3; c++) step("mid_pre", 1'b1, 3'b001);
        step("mid_rst", 1'b0, 3'b001);
        check_bit("mid_rst.out0", out0, 1'b0);
        check_bit("mid_rst.out1", out1, 1'b0);
        if (IN_REG) step("mid_fill", 1'b1, 3'b001);
        for (int c = 0; c < 6; c++) begin
            step("mid_post", 1'b1, 3'b001);
            check_bit($sformatf("mid_post[%0d].out1", c), out1, seq_exp[c]);
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 300; c++) begin
            rx = 3'($urandom_range(0, 7));
            rr = ($urandom_range(0, 15) != 0);
            step("rand", rr, rx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "timeout");
    end

endmodule : tb_simple_circuit
